// File: rtl/bcd_seq_conv_pkg.sv
// Shared FSM state codes and digit constants for the sequential binary-to-BCD converter.
package bcd_seq_conv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_ADJ   = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [3:0] XS3_BIAS  = 4'd3;
    localparam logic [3:0] ADD3_MIN  = 4'd5;
    localparam logic [3:0] MAX_DIGIT = 4'd9;

endpackage

// File: rtl/bcd_seq_conv_digit_adj.sv
// One BCD digit adder: adds the bias when the digit is >= 5 (double dabble) or when forced
// (excess-3 recoding).
module bcd_digit_adj
    import bcd_seq_conv_pkg::*;
(
    input  logic [3:0] digit_i,
    input  logic       cond_en_i,
    input  logic       force_i,
    output logic [3:0] digit_o
);

    logic add_bias;

    assign add_bias = force_i | (cond_en_i & (digit_i >= ADD3_MIN));
    assign digit_o  = add_bias ? digit_i + XS3_BIAS : digit_i;

endmodule

// File: rtl/bcd_seq_conv.sv
// Sequential shift-and-add-3 binary-to-BCD converter with optional excess-3 output,
// one shift per clock and valid/ready handshakes on both sides.
module bcd_seq_conv
    import bcd_seq_conv_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  in_clk,
    input  logic                  in_rst_n,
    input  logic                  in_valid,
    input  logic [BIN_W-1:0]      in_bin,
    input  logic                  in_mode,
    output logic                  out_ready,
    output logic                  out_valid,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic                  out_ovf,
    input  logic                  in_ready
);

    localparam int RES_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(BIN_W - 1);

    state_e               state_q;
    logic [BIN_W-1:0]     bin_q;
    logic [RES_W-1:0]     dig_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 mode_q;
    logic                 ovf_q;
    logic                 ready_q;
    logic                 valid_q;

    logic [RES_W-1:0]       dig_adj;
    logic [RES_W+BIN_W-1:0] shift_d;
    logic                   any_gt9;

    // SHIFT uses the conditional +3; ADJ reuses the same adders as a forced excess-3 bias.
    for (genvar d = 0; d < DIGITS; d++) begin : g_digit
        bcd_digit_adj u_adj (
            .digit_i   (dig_q[4*d +: 4]),
            .cond_en_i (state_q == ST_SHIFT),
            .force_i   (mode_q && (state_q == ST_ADJ)),
            .digit_o   (dig_adj[4*d +: 4])
        );
    end

    assign shift_d = {dig_adj, bin_q} << 1;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        any_gt9 = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            if (dig_q[4*d +: 4] > MAX_DIGIT) any_gt9 = 1'b1;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q <= ST_IDLE;
            bin_q   <= '0;
            dig_q   <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            ovf_q   <= 1'b0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        bin_q   <= in_bin;
                        mode_q  <= in_mode;
                        dig_q   <= '0;
                        cnt_q   <= '0;
                        ovf_q   <= 1'b0;
                        ready_q <= 1'b0;
                        state_q <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    dig_q <= shift_d[RES_W+BIN_W-1:BIN_W];
                    bin_q <= shift_d[BIN_W-1:0];
                    // The bit shifted out of the top digit means the value does not fit.
                    ovf_q <= ovf_q | dig_adj[RES_W-1];
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_SHIFT) state_q <= ST_ADJ;
                end
                ST_ADJ: begin
                    dig_q   <= dig_adj;
                    ovf_q   <= ovf_q | any_gt9;
                    valid_q <= 1'b1;
                    state_q <= ST_DONE;
                end
                ST_DONE: begin
                    if (in_ready) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign out_ready = ready_q;
    assign out_valid = valid_q;
    assign out_bcd   = dig_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_bcd_seq_conv.sv
// Scoreboard bench for bcd_seq_conv: three instances (8b/3 digits, 8b/2 digits, 1b/1 digit)
// share clock, reset and stimulus; sel chooses which one is driven and observed.
module tb_bcd_seq_conv;

    typedef struct {
        logic [11:0] bcd;
        logic        ovf;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       valid;
    logic [7:0] bin;
    logic       mode;
    logic       rdy;
    int         sel;

    logic a_ready, a_ovalid, a_ovf;
    logic b_ready, b_ovalid, b_ovf;
    logic c_ready, c_ovalid, c_ovf;
    logic [11:0] a_bcd;
    logic [7:0]  b_bcd;
    logic [3:0]  c_bcd;

    logic        cur_ready, cur_ovalid, cur_ovf;
    logic [11:0] cur_bcd;

    exp_t sb_q[$];
    int   n_pass;
    int   n_total;
    int   cyc;
    int   accept_cyc;

    bcd_seq_conv #(.BIN_W(8), .DIGITS(3)) u_dut_a (
        .in_clk(clk), .in_rst_n(rst_n), .in_valid(valid && sel == 0), .in_bin(bin),
        .in_mode(mode), .out_ready(a_ready), .out_valid(a_ovalid), .out_bcd(a_bcd),
        .out_ovf(a_ovf), .in_ready(rdy)
    );

    bcd_seq_conv #(.BIN_W(8), .DIGITS(2)) u_dut_b (
        .in_clk(clk), .in_rst_n(rst_n), .in_valid(valid && sel == 1), .in_bin(bin),
        .in_mode(mode), .out_ready(b_ready), .out_valid(b_ovalid), .out_bcd(b_bcd),
        .out_ovf(b_ovf), .in_ready(rdy)
    );

    bcd_seq_conv #(.BIN_W(1), .DIGITS(1)) u_dut_c (
        .in_clk(clk), .in_rst_n(rst_n), .in_valid(valid && sel == 2), .in_bin(bin[0:0]),
        .in_mode(mode), .out_ready(c_ready), .out_valid(c_ovalid), .out_bcd(c_bcd),
        .out_ovf(c_ovf), .in_ready(rdy)
    );

    always_comb begin
        cur_ready  = a_ready;
        cur_ovalid = a_ovalid;
        cur_bcd    = a_bcd;
        cur_ovf    = a_ovf;
        case (sel)
            1: begin
                cur_ready = b_ready; cur_ovalid = b_ovalid;
                cur_bcd = {4'h0, b_bcd}; cur_ovf = b_ovf;
            end
            2: begin
                cur_ready = c_ready; cur_ovalid = c_ovalid;
                cur_bcd = {8'h00, c_bcd}; cur_ovf = c_ovf;
            end
            default: ;
        endcase
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int bin_w_of(input int s);
        return (s == 2) ? 1 : 8;
    endfunction

    // Decimal reference: low `digits` digits, optional +3 per digit, overflow if v >= 10^digits.
    function automatic logic [12:0] model(input int v, input int digits, input logic m);
        logic [11:0] r;
        int x;
        int lim;
        r = '0;
        x = v;
        lim = 1;
        for (int i = 0; i < digits; i++) begin
            r[4*i +: 4] = 4'(x % 10) + (m ? 4'd3 : 4'd0);
            x = x / 10;
            lim = lim * 10;
        end
        return {(v >= lim), r};
    endfunction

    task automatic start_conv(input int s, input logic [7:0] b, input logic m,
                              input logic [11:0] eb, input logic eo);
        exp_t e;
        int waited;
        waited = 0;
        sel = s;
        while (!cur_ready && waited < 100) begin
            @(posedge clk); #1;
            waited++;
        end
        n_total++;
        if (cur_ready !== 1'b1) $display("FAIL ready_wait sel=%0d: out_ready=%b, required 1", s, cur_ready);
        else n_pass++;
        bin   = b;
        mode  = m;
        valid = 1'b1;
        e.bcd = eb;
        e.ovf = eo;
        sb_q.push_back(e);
        @(posedge clk);
        accept_cyc = cyc;
        #1;
        valid = 1'b0;
        bin   = ~b;
        mode  = ~m;
    endtask

    task automatic wait_result(input string name);
        exp_t e;
        int edges;
        edges = 1;
        while (!cur_ovalid && edges < 100) begin
            @(posedge clk); #1;
            edges++;
        end
        n_total++;
        if (cur_ovalid !== 1'b1 || sb_q.size() == 0) begin
            $display("FAIL %s timeout: out_valid=%b after %0d edges, required 1", name, cur_ovalid, edges);
            sb_q.delete();
            return;
        end
        n_pass++;
        e = sb_q.pop_front();
        n_total++;
        if (cur_bcd !== e.bcd) $display("FAIL %s bcd: got %h, required %h", name, cur_bcd, e.bcd);
        else n_pass++;
        n_total++;
        if (cur_ovf !== e.ovf) $display("FAIL %s ovf: got %b, required %b", name, cur_ovf, e.ovf);
        else n_pass++;
        n_total++;
        if (edges !== bin_w_of(sel) + 2)
            $display("FAIL %s latency: got %0d edges, required %0d", name, edges, bin_w_of(sel) + 2);
        else n_pass++;
    endtask

    task automatic finish_result(input string name);
        @(posedge clk); #1;
        n_total++;
        if (cur_ovalid !== 1'b0 || cur_ready !== 1'b1)
            $display("FAIL %s release: valid=%b ready=%b, required valid=0 ready=1", name, cur_ovalid, cur_ready);
        else n_pass++;
    endtask

    task automatic convert(input string name, input int s, input logic [7:0] b, input logic m,
                           input logic [11:0] eb, input logic eo);
        start_conv(s, b, m, eb, eo);
        wait_result(name);
        finish_result(name);
    endtask

    task automatic test_reset();
        n_total++;
        if (a_ready !== 1'b1 || a_ovalid !== 1'b0 || a_bcd !== 12'h000 || a_ovf !== 1'b0)
            $display("FAIL reset_a: ready=%b valid=%b bcd=%h ovf=%b, required 1 0 000 0",
                     a_ready, a_ovalid, a_bcd, a_ovf);
        else n_pass++;
        n_total++;
        if (b_ready !== 1'b1 || b_ovalid !== 1'b0 || c_ready !== 1'b1 || c_ovalid !== 1'b0)
            $display("FAIL reset_bc: b ready/valid=%b%b c ready/valid=%b%b, required 10 10",
                     b_ready, b_ovalid, c_ready, c_ovalid);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        convert("bcd_255", 0, 8'd255, 1'b0, 12'h255, 1'b0);
        convert("xs3_255", 0, 8'd255, 1'b1, 12'h588, 1'b0);
        convert("bcd_0",   0, 8'd0,   1'b0, 12'h000, 1'b0);
        convert("xs3_0",   0, 8'd0,   1'b1, 12'h333, 1'b0);
        convert("bcd_9",   0, 8'd9,   1'b0, 12'h009, 1'b0);
    endtask

    task automatic test_overflow();
        convert("ovf_100",     1, 8'd100, 1'b0, 12'h000, 1'b1);
        convert("fit_99",      1, 8'd99,  1'b0, 12'h099, 1'b0);
        convert("ovf_255_xs3", 1, 8'd255, 1'b1, 12'h088, 1'b1);
    endtask

    task automatic test_bin_w1();
        convert("w1_one",     2, 8'd1, 1'b0, 12'h001, 1'b0);
        convert("w1_one_xs3", 2, 8'd1, 1'b1, 12'h004, 1'b0);
        convert("w1_zero",    2, 8'd0, 1'b1, 12'h003, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [12:0] r;
        int v;
        int prev_accept;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 5; i++) begin
                v = int'($urandom_range(255, 0));
                r = model(v, (s == 0) ? 3 : 2, 1'(i % 2));
                start_conv(s, 8'(v), 1'(i % 2), r[11:0], r[12]);
                if (i > 0) begin
                    n_total++;
                    if (accept_cyc - prev_accept !== bin_w_of(s) + 3)
                        $display("FAIL throughput sel=%0d: got %0d cycles, required %0d",
                                 s, accept_cyc - prev_accept, bin_w_of(s) + 3);
                    else n_pass++;
                end
                prev_accept = accept_cyc;
                wait_result("b2b");
                finish_result("b2b");
            end
        end
    endtask

    task automatic test_backpressure();
        int bad;
        bad = 0;
        rdy = 1'b0;
        start_conv(0, 8'd142, 1'b0, 12'h142, 1'b0);
        wait_result("bp_result");
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin
                valid = 1'b1;
                bin   = 8'd7;
            end else begin
                valid = 1'b0;
            end
            @(posedge clk); #1;
            if (cur_ovalid !== 1'b1 || cur_bcd !== 12'h142 || cur_ovf !== 1'b0 || cur_ready !== 1'b0)
                bad++;
        end
        valid = 1'b0;
        n_total++;
        if (bad !== 0) $display("FAIL bp_hold: %0d unstable cycles, required 0", bad);
        else n_pass++;
        rdy = 1'b1;
        finish_result("bp_release");
        @(posedge clk); #1;
        n_total++;
        if (cur_ready !== 1'b1 || cur_ovalid !== 1'b0)
            $display("FAIL bp_ignored: ready=%b valid=%b, required 1 0", cur_ready, cur_ovalid);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        start_conv(0, 8'd200, 1'b0, 12'h200, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if (cur_ready !== 1'b0 || cur_bcd !== 12'h006)
            $display("FAIL mid_shift: ready=%b bcd=%h, required 0 006", cur_ready, cur_bcd);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_total++;
        if (cur_ready !== 1'b1 || cur_ovalid !== 1'b0 || cur_bcd !== 12'h000 || cur_ovf !== 1'b0)
            $display("FAIL async_reset: ready=%b valid=%b bcd=%h ovf=%b, required 1 0 000 0",
                     cur_ready, cur_ovalid, cur_bcd, cur_ovf);
        else n_pass++;
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        convert("after_reset_37", 0, 8'd37, 1'b0, 12'h037, 1'b0);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst_n   = 1'b0;
        valid   = 1'b0;
        bin     = 8'd0;
        mode    = 1'b0;
        rdy     = 1'b1;
        sel     = 0;
        #12;
        test_reset();
        test_basic();
        test_overflow();
        test_bin_w1();
        test_back_to_back();
        test_backpressure();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
